// File: rtl/mem_word_buffer.sv
// Word buffer behind mem_control: stores arriving UART words, flags when a frame
// is complete, and streams the stored words out over valid/ready on request.
module mem_word_buffer #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned NUM_W      = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memctrl_mem_write_start,
    input  logic [WORD_WIDTH-1:0] memctrl_mem_write_data,
    input  logic                  memctrl_mem_read,
    input  logic [NUM_W-1:0]      word_number,
    output logic                  mem_write_done,
    output logic                  mem_out_valid,
    output logic [WORD_WIDTH-1:0] mem_out_data,
    input  logic                  mem_out_ready,
    output logic [NUM_W-1:0]      mem_word_count,
    output logic                  mem_full,
    output logic                  mem_empty,
    output logic                  mem_overflow
);

    typedef enum logic [1:0] {StIdle, StFill, StDrain} state_e;

    state_e                state_q;
    logic [WORD_WIDTH-1:0] ram [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_q;
    logic [NUM_W-1:0]      rd_idx_q;
    logic [NUM_W-1:0]      count_q;
    logic                  done_sent_q;
    logic                  wr_accept;
    logic [NUM_W-1:0]      count_inc;

    assign mem_word_count = count_q;
    assign mem_full       = (count_q == NUM_W'(DEPTH));
    assign mem_empty      = (count_q == '0);
    assign count_inc      = count_q + NUM_W'(1);
    assign wr_accept      = memctrl_mem_write_start && (state_q != StDrain) && !mem_full;

    // Storage is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            ram[wr_ptr_q] <= memctrl_mem_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= StIdle;
            wr_ptr_q       <= '0;
            rd_idx_q       <= '0;
            count_q        <= '0;
            done_sent_q    <= 1'b0;
            mem_write_done <= 1'b0;
            mem_out_valid  <= 1'b0;
            mem_out_data   <= '0;
            mem_overflow   <= 1'b0;
        end else begin
            mem_write_done <= 1'b0;
            if (memctrl_mem_write_start && !wr_accept) begin
                mem_overflow <= 1'b1;
            end
            unique case (state_q)
                StIdle, StFill: begin
                    if (wr_accept) begin
                        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                        count_q  <= count_inc;
                        state_q  <= StFill;
                        if ((count_inc == word_number) && (word_number != '0) && !done_sent_q) begin
                            mem_write_done <= 1'b1;
                            done_sent_q    <= 1'b1;
                        end
                    end
                    // A same-cycle write counts towards the drain.
                    if (memctrl_mem_read && (wr_accept || (count_q != '0))) begin
                        state_q  <= StDrain;
                        rd_idx_q <= '0;
                    end
                end
                StDrain: begin
                    // rd_idx_q is the next word to fetch; it equals count_q once the
                    // last word is sitting on the output.
                    if (!mem_out_valid) begin
                        mem_out_data  <= ram[rd_idx_q[ADDR_W-1:0]];
                        mem_out_valid <= 1'b1;
                        rd_idx_q      <= rd_idx_q + NUM_W'(1);
                    end else if (mem_out_ready) begin
                        if (rd_idx_q == count_q) begin
                            state_q       <= StIdle;
                            count_q       <= '0;
                            wr_ptr_q      <= '0;
                            rd_idx_q      <= '0;
                            done_sent_q   <= 1'b0;
                            mem_out_valid <= 1'b0;
                        end else begin
                            mem_out_data <= ram[rd_idx_q[ADDR_W-1:0]];
                            rd_idx_q     <= rd_idx_q + NUM_W'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_word_buffer.sv
// Scoreboard bench for mem_word_buffer: writes push expected words, a negedge
// monitor pops and compares every valid&ready handshake.
module tb_mem_word_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        memctrl_mem_write_start;
    logic [31:0] memctrl_mem_write_data;
    logic        memctrl_mem_read;
    logic [4:0]  word_number;
    logic        mem_write_done;
    logic        mem_out_valid;
    logic [31:0] mem_out_data;
    logic        mem_out_ready;
    logic [4:0]  mem_word_count;
    logic        mem_full;
    logic        mem_empty;
    logic        mem_overflow;

    int          errors = 0;
    int          checks = 0;
    int          mcount = 0;
    logic [31:0] exp_q[$];

    mem_word_buffer dut (
        .clk                     (clk),
        .reset                   (reset),
        .memctrl_mem_write_start (memctrl_mem_write_start),
        .memctrl_mem_write_data  (memctrl_mem_write_data),
        .memctrl_mem_read        (memctrl_mem_read),
        .word_number             (word_number),
        .mem_write_done          (mem_write_done),
        .mem_out_valid           (mem_out_valid),
        .mem_out_data            (mem_out_data),
        .mem_out_ready           (mem_out_ready),
        .mem_word_count          (mem_word_count),
        .mem_full                (mem_full),
        .mem_empty               (mem_empty),
        .mem_overflow            (mem_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] w, input logic rd);
        memctrl_mem_write_start = 1'b1;
        memctrl_mem_write_data  = w;
        memctrl_mem_read        = rd;
        if (mcount < 16) begin
            exp_q.push_back(w);
            mcount++;
        end
        tick();
        memctrl_mem_write_start = 1'b0;
        memctrl_mem_read        = 1'b0;
    endtask

    task automatic read_strobe();
        memctrl_mem_read = 1'b1;
        tick();
        memctrl_mem_read = 1'b0;
    endtask

    // Waits until every expected word is consumed and valid drops; counts cycles
    // in which the overflow flag was seen low.
    task automatic wait_drain(input string name, output int ovf_low);
        int n;
        n       = 0;
        ovf_low = 0;
        while ((mem_out_valid || exp_q.size() != 0) && n < 200) begin
            tick();
            n++;
            if (!mem_overflow) ovf_low++;
        end
        check({name, "_timeout"}, (n >= 200) ? 32'd1 : 32'd0, 32'd0);
        check({name, "_queue_left"}, exp_q.size(), 32'd0);
        mcount = 0;
    endtask

    // Monitor: compares handshaken words and checks stability during stalls.
    initial begin
        logic        held;
        logic [31:0] held_data;
        held = 1'b0;
        held_data = '0;
        forever begin
            @(negedge clk);
            if (held) begin
                check("stall_valid", mem_out_valid, 32'd1);
                check("stall_data", mem_out_data, held_data);
            end
            held      = mem_out_valid && !mem_out_ready;
            held_data = mem_out_data;
            if (mem_out_valid && mem_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'd1, 32'd0);
                end else begin
                    check("out_data", mem_out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] frame [4];
        bit          pat [5];
        int          ovf_low;

        frame = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
        pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        reset                   = 1'b0;
        memctrl_mem_write_start = 1'b0;
        memctrl_mem_write_data  = '0;
        memctrl_mem_read        = 1'b0;
        word_number             = 5'd4;
        mem_out_ready           = 1'b0;
        tick();
        tick();
        check("rst_valid", mem_out_valid, 0);
        check("rst_count", mem_word_count, 0);
        check("rst_empty", mem_empty, 1);
        check("rst_full", mem_full, 0);
        check("rst_overflow", mem_overflow, 0);
        check("rst_done", mem_write_done, 0);
        check("rst_data", mem_out_data, 0);
        reset = 1'b1;
        tick();

        // Frame of four words, done pulse after the 4th only.
        for (int i = 0; i < 4; i++) begin
            write_word(frame[i], 1'b0);
            check("fill_count", mem_word_count, i + 1);
            check("fill_done", mem_write_done, (i == 3) ? 32'd1 : 32'd0);
            tick();
            check("done_gap", mem_write_done, 0);
        end

        // Readout with ready high: valid after N+1, four back-to-back words.
        mem_out_ready = 1'b1;
        read_strobe();
        check("latency_valid_n", mem_out_valid, 0);
        tick();
        check("latency_valid_n1", mem_out_valid, 1);
        check("first_word", mem_out_data, 32'h11223344);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("burst_valid", mem_out_valid, 1);
        end
        tick();
        check("burst_end_valid", mem_out_valid, 0);
        check("burst_end_empty", mem_empty, 1);
        check("burst_end_count", mem_word_count, 0);
        check("burst_queue_left", exp_q.size(), 0);
        mcount = 0;

        // Three words drained with ready toggling.
        mem_out_ready = 1'b0;
        word_number   = 5'd3;
        write_word(32'hA0A0A0A0, 1'b0);
        write_word(32'hB1B1B1B1, 1'b0);
        write_word(32'hC2C2C2C2, 1'b0);
        read_strobe();
        tick();
        check("toggle_valid_up", mem_out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            mem_out_ready = pat[i];
            tick();
        end
        check("toggle_end_valid", mem_out_valid, 0);
        check("toggle_queue_left", exp_q.size(), 0);
        mcount = 0;

        // Seventeen writes: 16 stored, 17th dropped, overflow sticky through drain.
        word_number   = 5'd0;
        mem_out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            write_word(32'h1000 + i, 1'b0);
            if (i == 14) check("full_at_15", mem_full, 0);
            if (i == 15) begin
                check("full_at_16", mem_full, 1);
                check("no_done_wn0", mem_write_done, 0);
                check("ovf_at_16", mem_overflow, 0);
            end
        end
        check("count_after_17", mem_word_count, 16);
        check("ovf_after_17", mem_overflow, 1);
        read_strobe();
        wait_drain("drain16", ovf_low);
        check("ovf_sticky", ovf_low, 0);
        check("drain16_empty", mem_empty, 1);
        check("drain16_ovf", mem_overflow, 1);

        // Read with nothing stored is ignored.
        read_strobe();
        tick();
        check("empty_read_valid", mem_out_valid, 0);
        tick();
        check("empty_read_valid2", mem_out_valid, 0);
        check("empty_read_count", mem_word_count, 0);

        // Simultaneous write+read with two stored drains three words.
        write_word(32'hCAFE0001, 1'b0);
        write_word(32'hCAFE0002, 1'b0);
        write_word(32'hCAFE0003, 1'b1);
        check("simul_count", mem_word_count, 3);
        wait_drain("simul", ovf_low);
        check("simul_empty", mem_empty, 1);

        // Reset in the middle of a four-word drain.
        word_number = 5'd4;
        for (int i = 0; i < 4; i++) write_word(32'hD0D0_0000 + i, 1'b0);
        read_strobe();
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_q.delete();
        mcount = 0;
        check("midrst_valid", mem_out_valid, 0);
        check("midrst_count", mem_word_count, 0);
        check("midrst_ovf", mem_overflow, 0);
        tick();
        check("midrst_valid2", mem_out_valid, 0);

        // Fresh two-word frame after reset.
        word_number = 5'd2;
        write_word(32'h0BADF00D, 1'b0);
        write_word(32'hFEEDBEEF, 1'b0);
        check("post_done", mem_write_done, 1);
        check("post_count", mem_word_count, 2);
        read_strobe();
        wait_drain("post", ovf_low);
        check("post_empty", mem_empty, 1);
        check("post_ovf", mem_overflow, 0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
